// File: rtl/grf_pkg.sv
// Shared definitions for the GRF write-port scheduler slice.
package grf_pkg;

  localparam int         REG_ADDR_W = 5;
  localparam int         NUM_REGS   = 32;
  localparam logic [4:0] ZERO_REG   = 5'd0;

  // One pending GRF write: destination, value and the PC that produced it.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [31:0]           data;
    logic [31:0]           pc;
  } grf_wreq_t;

endpackage

// File: rtl/grf_scoreboard.sv
// Busy scoreboard for registers waiting on a long-latency result.
// One set port (issue), one clear port (LU write), three read ports.
module grf_scoreboard
  import grf_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  rs_busy,
  output logic                  rt_busy,
  output logic                  rd_busy
);

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_next_s;
  logic [NUM_REGS-1:0] set_mask_s;
  logic [NUM_REGS-1:0] clr_mask_s;

  // Next busy vector: clear the written register, set the newly issued one, $0 never busy.
  always_comb begin
    set_mask_s  = {{(NUM_REGS-1){1'b0}}, set_en} << set_addr;
    clr_mask_s  = {{(NUM_REGS-1){1'b0}}, clr_en} << clr_addr;
    busy_next_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~{{(NUM_REGS-1){1'b0}}, 1'b1};
  end

  // Busy state register; reset drops every pending mark.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

  assign rs_busy = busy_r[rs_addr];
  assign rt_busy = busy_r[rt_addr];
  assign rd_busy = busy_r[rd_addr];

endmodule

// File: rtl/grf_write_scheduler.sv
// Shares the GRF write port between the WB stage (fixed priority) and a
// one-entry buffered long-latency unit, and stalls issue on hazards
// against pending LU destinations or when the buffered result starves.
module grf_write_scheduler
  import grf_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  input  logic [4:0]  issue_rd,
  input  logic        issue_long,
  output logic        issue_stall,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_addr,
  input  logic [31:0] lu_data,
  input  logic [31:0] lu_pc,
  output logic        grf_we,
  output logic [4:0]  grf_waddr,
  output logic [31:0] grf_wdata,
  output logic [31:0] grf_pc
);

  localparam logic [CNT_W-1:0] STARVE_LIM_C = CNT_W'(STARVE_LIMIT);

  grf_wreq_t        buf_r;
  logic             buf_full_r;
  logic [CNT_W-1:0] cnt_r;

  logic wb_req_s;
  logic drain_s;
  logic capture_s;
  logic starve_s;
  logic set_en_s;
  logic rs_busy_s;
  logic rt_busy_s;
  logic rd_busy_s;

  // A WB request to $0 is treated as no request so the buffer can drain.
  assign wb_req_s  = wb_valid && (wb_addr != ZERO_REG);
  assign drain_s   = reset && buf_full_r && !wb_req_s;
  assign lu_ready  = reset && !buf_full_r;
  // LU results for $0 complete the handshake but are never stored.
  assign capture_s = lu_valid && lu_ready && (lu_addr != ZERO_REG);
  assign starve_s  = (cnt_r >= STARVE_LIM_C);

  // Stall on RAW/WAW against pending LU results or to force a WB bubble.
  assign issue_stall = !reset ||
                       (issue_valid && (rs_busy_s || rt_busy_s ||
                                        (issue_long && rd_busy_s) || starve_s));
  assign set_en_s    = issue_valid && !issue_stall && issue_long &&
                       (issue_rd != ZERO_REG);

  grf_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (set_en_s),
    .set_addr (issue_rd),
    .clr_en   (drain_s),
    .clr_addr (buf_r.addr),
    .rs_addr  (issue_rs),
    .rt_addr  (issue_rt),
    .rd_addr  (issue_rd),
    .rs_busy  (rs_busy_s),
    .rt_busy  (rt_busy_s),
    .rd_busy  (rd_busy_s)
  );

  // Write-port mux: WB first, then the buffered LU result, else idle zeros.
  always_comb begin
    grf_we    = 1'b0;
    grf_waddr = 5'd0;
    grf_wdata = 32'd0;
    grf_pc    = 32'd0;
    if (!reset) begin
      grf_we = 1'b0;
    end else if (wb_req_s) begin
      grf_we    = 1'b1;
      grf_waddr = wb_addr;
      grf_wdata = wb_data;
      grf_pc    = wb_pc;
    end else if (buf_full_r) begin
      grf_we    = 1'b1;
      grf_waddr = buf_r.addr;
      grf_wdata = buf_r.data;
      grf_pc    = buf_r.pc;
    end else begin
      grf_we = 1'b0;
    end
  end

  // One-entry LU buffer: fill only when empty, empty only when it wins the port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_full_r <= 1'b0;
      buf_r      <= '{addr: 5'd0, data: 32'd0, pc: 32'd0};
    end else if (capture_s) begin
      buf_full_r <= 1'b1;
      buf_r      <= '{addr: lu_addr, data: lu_data, pc: lu_pc};
    end else if (drain_s) begin
      buf_full_r <= 1'b0;
    end else begin
      buf_full_r <= buf_full_r;
    end
  end

  // Starvation counter: counts cycles a held result loses to WB, saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!buf_full_r || drain_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r < STARVE_LIM_C) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_grf_write_scheduler.sv
// Scoreboard bench: stimulus pushes expected GRF writes, a negedge monitor
// pops and compares whenever a write is expected or presented.
module tb_grf_write_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rs, issue_rt, issue_rd;
  logic        issue_long;
  logic        issue_stall;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, wb_pc;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data, lu_pc;
  logic        grf_we;
  logic [4:0]  grf_waddr;
  logic [31:0] grf_wdata, grf_pc;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] p;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  grf_write_scheduler #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_rd(issue_rd), .issue_long(issue_long), .issue_stall(issue_stall),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr),
    .lu_data(lu_data), .lu_pc(lu_pc),
    .grf_we(grf_we), .grf_waddr(grf_waddr), .grf_wdata(grf_wdata), .grf_pc(grf_pc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    exp_t e;
    e.a = a; e.d = d; e.p = p;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic lng);
    issue_valid = v; issue_rs = rs; issue_rt = rt; issue_rd = rd; issue_long = lng;
  endtask

  task automatic wb(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    wb_valid = v; wb_addr = a; wb_data = d; wb_pc = p;
  endtask

  task automatic lu(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    lu_valid = v; lu_addr = a; lu_data = d; lu_pc = p;
  endtask

  // Monitor: every presented or expected GRF write is checked against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (grf_we === 1'b1 || exp_q.size() > 0) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL grf_unexpected: got we=1 addr=%0d data=%0h pc=%0h expected no write",
                 grf_waddr, grf_wdata, grf_pc);
      end else begin
        e = exp_q.pop_front();
        if (grf_we !== 1'b1 || grf_waddr !== e.a || grf_wdata !== e.d || grf_pc !== e.p) begin
          fails++;
          $display("FAIL grf_write: got we=%0b addr=%0d data=%0h pc=%0h expected we=1 addr=%0d data=%0h pc=%0h",
                   grf_we, grf_waddr, grf_wdata, grf_pc, e.a, e.d, e.p);
        end
      end
    end
  end

  initial begin
    // Reset held with requests present on every input.
    reset = 1'b0;
    issue(1'b1, 5'd8, 5'd9, 5'd0, 1'b0);
    wb(1'b1, 5'd7, 32'h7777, 32'h70);
    lu(1'b1, 5'd4, 32'h4444, 32'h40);
    repeat (2) @(posedge clk);
    samp();
    chk("rst_lu_ready", {63'd0, lu_ready}, 64'd0);
    chk("rst_stall", {63'd0, issue_stall}, 64'd1);
    chk("rst_grf_we", {63'd0, grf_we}, 64'd0);

    tick();
    reset = 1'b1;
    wb(1'b0, 5'd0, 32'd0, 32'd0);
    lu(1'b0, 5'd0, 32'd0, 32'd0);
    samp();
    chk("rel_lu_ready", {63'd0, lu_ready}, 64'd1);
    chk("rel_stall_busy0", {63'd0, issue_stall}, 64'd0);

    // Long op to r8, RAW stall, LU return, stall release one cycle after write.
    tick();
    issue(1'b1, 5'd1, 5'd2, 5'd8, 1'b1);
    samp();
    chk("iss8_stall", {63'd0, issue_stall}, 64'd0);
    tick();
    issue(1'b1, 5'd8, 5'd2, 5'd0, 1'b0);
    samp();
    chk("raw8_stall", {63'd0, issue_stall}, 64'd1);
    tick();
    lu(1'b1, 5'd8, 32'h1234, 32'h100);
    samp();
    chk("lu8_ready", {63'd0, lu_ready}, 64'd1);
    tick();
    lu(1'b0, 5'd0, 32'd0, 32'd0);
    push(5'd8, 32'h1234, 32'h100);
    samp();
    chk("lu8_full_ready", {63'd0, lu_ready}, 64'd0);
    chk("raw8_stall_wr", {63'd0, issue_stall}, 64'd1);
    tick();
    samp();
    chk("raw8_release", {63'd0, issue_stall}, 64'd0);

    // Starvation: buffer holds r9 while WB wins every cycle.
    tick();
    issue(1'b1, 5'd1, 5'd2, 5'd0, 1'b0);
    lu(1'b1, 5'd9, 32'hAAAA, 32'h200);
    wb(1'b1, 5'd10, 32'h10, 32'h300);
    push(5'd10, 32'h10, 32'h300);
    samp();
    chk("st_cap_stall", {63'd0, issue_stall}, 64'd0);
    tick();
    lu(1'b0, 5'd0, 32'd0, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      wb(1'b1, 5'(10 + k), 32'(k), 32'h300 + 32'(k));
      push(5'(10 + k), 32'(k), 32'h300 + 32'(k));
      samp();
      chk($sformatf("starve_k%0d", k), {63'd0, issue_stall}, (k >= 5) ? 64'd1 : 64'd0);
      tick();
    end
    wb(1'b0, 5'd0, 32'd0, 32'd0);
    push(5'd9, 32'hAAAA, 32'h200);
    samp();
    chk("starve_drain_stall", {63'd0, issue_stall}, 64'd1);
    tick();
    samp();
    chk("starve_cnt_clr", {63'd0, issue_stall}, 64'd0);
    chk("starve_empty", {63'd0, lu_ready}, 64'd1);

    // WB to $0 does not block the buffered r5 result.
    tick();
    lu(1'b1, 5'd5, 32'h55, 32'h500);
    tick();
    lu(1'b0, 5'd0, 32'd0, 32'd0);
    wb(1'b1, 5'd0, 32'hDEAD, 32'hBEEF);
    push(5'd5, 32'h55, 32'h500);
    samp();
    chk("wb0_full", {63'd0, lu_ready}, 64'd0);
    tick();
    wb(1'b0, 5'd0, 32'd0, 32'd0);
    samp();
    chk("wb0_drained", {63'd0, lu_ready}, 64'd1);

    // LU result to $0 is accepted and dropped.
    tick();
    lu(1'b1, 5'd0, 32'h77, 32'h700);
    samp();
    chk("lu0_ready", {63'd0, lu_ready}, 64'd1);
    tick();
    lu(1'b0, 5'd0, 32'd0, 32'd0);
    issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    samp();
    chk("lu0_still_empty", {63'd0, lu_ready}, 64'd1);
    chk("lu0_idle_outs", {grf_we, grf_waddr, grf_wdata[25:0]}, 64'd0);
    chk("lu0_idle_pc", {32'd0, grf_pc}, 64'd0);
    chk("lu0_no_busy", {63'd0, issue_stall}, 64'd0);

    // WAW on r3.
    tick();
    issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1);
    samp();
    chk("waw_first", {63'd0, issue_stall}, 64'd0);
    tick();
    samp();
    chk("waw_second", {63'd0, issue_stall}, 64'd1);
    tick();
    lu(1'b1, 5'd3, 32'h33, 32'h600);
    samp();
    chk("waw_lu_cap", {63'd0, issue_stall}, 64'd1);
    tick();
    lu(1'b0, 5'd0, 32'd0, 32'd0);
    push(5'd3, 32'h33, 32'h600);
    samp();
    chk("waw_on_write", {63'd0, issue_stall}, 64'd1);
    tick();
    samp();
    chk("waw_reissue", {63'd0, issue_stall}, 64'd0);
    tick();
    samp();
    chk("waw_reset_busy", {63'd0, issue_stall}, 64'd1);

    // Mid-operation reset discards buffered r12 and busy r3/r20.
    tick();
    issue(1'b1, 5'd1, 5'd2, 5'd20, 1'b1);
    lu(1'b1, 5'd12, 32'hC, 32'hC00);
    wb(1'b1, 5'd13, 32'hD, 32'hD00);
    push(5'd13, 32'hD, 32'hD00);
    samp();
    chk("mid_issue20", {63'd0, issue_stall}, 64'd0);
    tick();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    lu(1'b0, 5'd0, 32'd0, 32'd0);
    wb(1'b1, 5'd14, 32'hE, 32'hE00);
    push(5'd14, 32'hE, 32'hE00);
    samp();
    tick();
    reset = 1'b0;
    wb(1'b1, 5'd15, 32'hF, 32'hF00);
    samp();
    chk("mid_rst_we", {63'd0, grf_we}, 64'd0);
    chk("mid_rst_ready", {63'd0, lu_ready}, 64'd0);
    tick();
    reset = 1'b1;
    wb(1'b0, 5'd0, 32'd0, 32'd0);
    issue(1'b1, 5'd3, 5'd20, 5'd0, 1'b0);
    samp();
    chk("mid_buf_discard", {63'd0, lu_ready}, 64'd1);
    chk("mid_busy_clr", {63'd0, issue_stall}, 64'd0);

    tick();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    samp();
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/grf_write_scheduler.md
Name: grf_write_scheduler

Overview:
- Shares the single GRF write port between two producers:
  - the in-order pipeline write-back stage, which has fixed priority and no backpressure;
  - a long-latency unit (LU, e.g. mult/div), which uses a valid/ready handshake.
- Holds a 32-bit busy scoreboard of registers pending LU results and stalls issue on RAW/WAW hazards against them.
- Sits between the WB stage, the LU and the GRF write inputs (enable, address, data, PC for trace).

Parameters:
- STARVE_LIMIT, 4: number of consecutive cycles a buffered LU result may lose arbitration before issue is stalled to force a WB bubble.
- CNT_W, 3: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- issue_valid  in  1  an instruction is attempting to issue this cycle.
- issue_rs  in  5  source register 1 of the issuing instruction.
- issue_rt  in  5  source register 2 of the issuing instruction.
- issue_rd  in  5  destination register of an LU instruction.
- issue_long  in  1  the issuing instruction writes issue_rd through the LU.
- issue_stall  out  1  hold the issue stage this cycle.
- wb_valid  in  1  pipeline write-back request.
- wb_addr  in  5  pipeline write-back register.
- wb_data  in  32  pipeline write-back data.
- wb_pc  in  32  pipeline write-back PC.
- lu_valid  in  1  LU result available.
- lu_ready  out  1  scheduler can accept an LU result.
- lu_addr  in  5  LU result destination register.
- lu_data  in  32  LU result data.
- lu_pc  in  32  LU result PC.
- grf_we  out  1  GRF write enable.
- grf_waddr  out  5  GRF write address.
- grf_wdata  out  32  GRF write data.
- grf_pc  out  32  PC of the write, for trace.

Behaviour:
- Reset (reset==0, asynchronous):
  - LU buffer empty; busy[31:0]=0; starvation counter=0.
  - Outputs during reset: grf_we=0, lu_ready=0, issue_stall=1.
  - Reset mid-operation discards the buffered LU result and all busy bits.
- LU buffer (one entry: addr/data/pc):
  - lu_ready = buffer empty, combinational, and 0 in reset.
  - Capture on posedge when lu_valid && lu_ready.
  - A capture and a drain never occur in the same cycle; the minimum LU acceptance interval is 2 cycles.
- Write-port arbitration (combinational, 0-cycle latency to the GRF inputs):
  - If wb_valid && wb_addr!=0: grf_we=1 and grf_waddr/grf_wdata/grf_pc take the wb_* values. WB always wins.
  - Else if the buffer is full: grf_we=1 with the buffered fields; the buffer empties on that posedge.
  - Otherwise grf_we=0; addr/data/pc outputs drive 0.
  - wb_valid with wb_addr==0 counts as no request, so the buffer may drain that cycle.
- LU writes to $0:
  - Accepted and dropped; the buffer never holds addr 0 and grf_we is never asserted.
- Scoreboard:
  - busy[issue_rd] is set on posedge when issue_valid && !issue_stall && issue_long && issue_rd!=0.
  - busy[a] is cleared on the posedge where the buffered result for register a is written to the GRF.
  - busy[0] is always 0.
- Stall condition, combinational, evaluated on current busy:
  - issue_stall = issue_valid && (busy[issue_rs] || busy[issue_rt] || (issue_long && busy[issue_rd]) || starve), forced to 1 in reset.
  - The stall is released the cycle after the clearing write; there is no same-cycle bypass.
- Starvation counter:
  - Increments each cycle the buffer is full and WB wins; resets to 0 on a drain or when the buffer is empty.
  - starve = (cnt >= STARVE_LIMIT). The counter saturates at STARVE_LIMIT.
- Upstream contract:
  - The LU never returns a result for register r before an older pipeline write to r has reached WB.
  - LU minimum latency is at least the pipeline depth from issue to WB.
- The block performs no data arithmetic; all paths are pure muxing.

Decomposition:
- Shared package grf_pkg:
  - REG_ADDR_W=5, NUM_REGS=32, ZERO_REG=5'd0;
  - a typedef for the write request struct {addr, data, pc}.
- One sub-module, grf_scoreboard: holds busy[31:0] with set/clear ports and two read ports plus an rd port.

Test Plan:
- Reset: hold reset=0 with wb_valid=1 and lu_valid=1 → grf_we=0, lu_ready=0, issue_stall=1. Release → lu_ready=1, busy=0.
- Issue LU with rd=8 (issue_long=1) → busy[8]=1 next cycle. Then issue rs=8 → issue_stall=1. LU returns addr 8, data 0x1234, with no WB → grf_we=1, waddr=8, data 0x1234. busy[8]=0 and stall drops the following cycle.
- Buffer holds addr 9 while wb_valid=1 every cycle → WB writes pass each cycle. issue_stall asserts after 4 lost cycles. Drop wb_valid → buffer drains and the counter returns to 0.
- wb_valid=1 with wb_addr=0 while the buffer holds addr 5 → grf_we=1 with waddr=5.
- LU result to addr 0 → lu_ready handshake completes, grf_we stays 0, no busy change.
- Issue LU rd=3 while busy[3]=1 → issue_stall=1 (WAW); busy[3] is set again only after the first result writes.
